// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed multiplier, radix-8 Booth, one digit per clock.
// Optional registered Busy output when BOOTH_BUSY_EN is defined.
module booth_multiplier #(
  parameter int N = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic           Done,
  output logic [2*N-1:0] Product
`ifdef BOOTH_BUSY_EN
  ,
  output logic           Busy
`endif
);
  localparam int K = (N + 2) / 3;
  localparam int IW = $clog2(K + 1);
  localparam logic [2:0] IDLE = 3'd0, PRECOMP = 3'd1, ITER = 3'd2, DONE = 3'd3, WAIT = 3'd4;
  logic [2:0] state, state_nx;
  logic [N-1:0] mp, mc;
  logic [2*N-1:0] m, m3, acc, mag, pp, acc_nx;
  logic [3*K:0] y;
  logic [IW-1:0] idx;
  logic signed [2*N-1:0] mx;
  logic signed [3*K-1:0] yx;
  logic last;
  assign mx = $signed(mc);
  assign yx = $signed(mp);
  assign last = idx == IW'(K - 1);
  // y[3:0] always holds the current digit window, y[-1] sitting in bit 0
  always_comb begin
    case (y[3:0])
      4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = m;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = m << 1;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = m3;
      4'b0111, 4'b1000:                   mag = m << 2;
      default:                            mag = '0;
    endcase
  end
  assign pp = y[3] ? -mag : mag;
  assign acc_nx = acc + pp;
  always_comb begin
    state_nx = state == IDLE    ? (Start ? PRECOMP : IDLE) :
               state == PRECOMP ? ITER :
               state == ITER    ? (last ? DONE : ITER) :
               (Start ? WAIT : IDLE);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Done <= 1'b0;
      Product <= '0;
      mp <= '0;
      mc <= '0;
      m <= '0;
      m3 <= '0;
      acc <= '0;
      y <= '0;
      idx <= '0;
    end else begin
      state <= state_nx;
      Done <= state == ITER && last;
      if (state == IDLE && Start) begin
        mp <= Mplier;
        mc <= Mcand;
        acc <= '0;
      end
      if (state == PRECOMP) begin
        m <= mx;
        m3 <= mx + (mx <<< 1);
        y <= {yx, 1'b0};
        idx <= '0;
      end
      // multiplicands shift with the digit so the partial product lands at 3i
      if (state == ITER) begin
        acc <= acc_nx;
        m <= m << 3;
        m3 <= m3 << 3;
        y <= y >> 3;
        idx <= IW'(idx + 1'b1);
        if (last) Product <= acc_nx;
      end
    end
  end
`ifdef BOOTH_BUSY_EN
  always_ff @(posedge Clock) begin
    if (Reset) Busy <= 1'b0;
    else Busy <= state_nx == PRECOMP || state_nx == ITER || state_nx == DONE;
  end
`endif
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed vectors, scoreboard queue checked by a Done-driven monitor.
module tb_booth_multiplier;
  logic Clock = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic [7:0] Mplier = '0, Mcand = '0;
  logic Done;
  logic [15:0] Product;
`ifdef BOOTH_BUSY_EN
  logic busy;
`endif
  logic [15:0] sbq[$];
  int ncmp = 0, nerr = 0;

  booth_multiplier #(.N(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mplier(Mplier), .Mcand(Mcand),
    .Done(Done), .Product(Product)
`ifdef BOOTH_BUSY_EN
    , .Busy(busy)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset && Done) begin
      if (sbq.size() == 0) check("spurious_done", sbq.size(), 1);
      else check("product", {16'h0, Product}, {16'h0, sbq.pop_front()});
    end
  end

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input int hold);
    int first, pulses;
    first = -1;
    pulses = 0;
    @(negedge Clock);
    Mplier = a;
    Mcand = b;
    Start = 1'b1;
    sbq.push_back(exp);
    for (int c = 0; c < 12; c++) begin
      @(posedge Clock);
      #1;
      if (c + 1 >= hold) Start = 1'b0;
      Mplier = ~a;
      Mcand = ~b;
      if (Done) begin
        if (first < 0) first = c;
        pulses++;
      end
    end
    check("latency", first, 4);
    check("pulses", pulses, 1);
    check("product_hold", {16'h0, Product}, {16'h0, exp});
  endtask

  initial begin
    int p;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_done", Done, 0);
    check("reset_product", Product, 0);
    Reset = 1'b0;
    run(8'h66, 8'h33, 16'h1452, 1);
    run(8'hA6, 8'h66, 16'hDC24, 1);
    run(8'h6B, 8'h8E, 16'hD05A, 1);
    run(8'hCC, 8'h99, 16'h14EC, 1);
    run(8'h80, 8'h80, 16'h4000, 1);
    run(8'hFF, 8'hFF, 16'h0001, 1);
    run(8'h00, 8'h55, 16'h0000, 1);
    run(8'h7F, 8'h00, 16'h0000, 1);
    run(8'h7F, 8'h7F, 16'h3F01, 1);
    run(8'h80, 8'h7F, 16'hC080, 1);
    run(8'h01, 8'h80, 16'hFF80, 1);
    run(8'h03, 8'h05, 16'h000F, 2);
    run(8'hFD, 8'h05, 16'hFFF1, 10);
    @(negedge Clock);
    Mplier = 8'h66;
    Mcand = 8'h33;
    Start = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    Start = 1'b0;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("abort_done", Done, 0);
    check("abort_product", Product, 0);
    p = 0;
    repeat (8) begin
      @(posedge Clock);
      #1;
      if (Done) p++;
    end
    check("abort_no_done", p, 0);
    run(8'h66, 8'h33, 16'h1452, 1);
    repeat (2) @(posedge Clock);
    check("queue_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
